hamming_secded_decoder: RTL and testbench

Receive-side SECDED decoder for the 16-bit extended Hamming (15,11)+overall-parity codeword. It sits downstream of the noise channel in the Hamming test path. It accepts possibly-corrupted codewords over a valid/ready handshake and corrects any single-bit error. Double-bit errors are flagged as uncorrectable. It delivers 11-bit data through a 2-stage back-pressurable pipeline and keeps optional saturating error statistics.

---
 rtl/hamming_secded_decoder.sv | 162 ++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
// Receive-side SECDED decoder for the 16-bit extended Hamming (15,11) code.
// It has a 2-stage valid/ready pipeline with back-pressure:
//   S1 registers the codeword; syndrome and overall parity are computed from it.
//   S2 classifies the word, corrects a single error and registers the results.
// Optional saturating error counters are built in only when the
// HAMMING_DEC_STATS_EN macro is defined.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid        codeword present on in_codeword
//   in_ready        decoder can accept this cycle (combinational from out_ready)
//   in_codeword     bit 0 = overall parity, bits 1..15 = Hamming positions 1..15
//   out_valid       decoded result present
//   out_ready       downstream accepts this cycle
//   out_data        11-bit decoded data
//   out_single      single error detected and corrected
//   out_double      double error detected; data left uncorrected
//   out_err_pos     corrected bit index, 0 unless a single error is reported
//   stats_clear     synchronous clear of both counters
//   cnt_single      saturating count of delivered single errors
//   cnt_double      saturating count of delivered double errors
module hamming_secded_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_single,
  output logic             out_double,
  output logic [3:0]       out_err_pos,
  input  logic             stats_clear,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  localparam int unsigned CW_W   = 16;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned POS_W  = 4;

  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_code;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_single;
  logic              r_out_double;
  logic [POS_W-1:0]  r_out_err_pos;

  logic              w_s2_load;
  logic              w_s1_load;
  logic [POS_W-1:0]  w_syndrome;
  logic              w_parity;
  logic              w_syn_nz;
  logic [CW_W-1:0]   w_flip;
  logic [CW_W-1:0]   w_fixed;
  logic [DATA_W-1:0] w_data;
  logic              w_single;
  logic              w_double;
  logic [POS_W-1:0]  w_err_pos;

  // Pipeline advance: S2 frees when empty or drained; S1 frees when empty or moving on.
  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // Syndrome is the XOR of the indices of all set bits in positions 1..15.
  always_comb begin
    w_syndrome = '0;
    for (int i = 1; i < 16; i++) begin
      if (r_s1_code[i]) w_syndrome = w_syndrome ^ POS_W'(i);
    end
  end

  assign w_parity = ^r_s1_code;
  assign w_syn_nz = |w_syndrome;

  // Odd overall parity means a single error (bit 0 itself when the syndrome is 0);
  // even parity with a nonzero syndrome means a double error, left uncorrected.
  assign w_single  = w_parity;
  assign w_double  = !w_parity && w_syn_nz;
  assign w_flip    = (w_parity && w_syn_nz) ? (CW_W'(1) << w_syndrome) : '0;
  assign w_fixed   = r_s1_code ^ w_flip;
  assign w_err_pos = w_parity ? w_syndrome : '0;

  // Data bits live at positions 3,5,6,7,9..15 (LSB first).
  assign w_data = {w_fixed[15:9], w_fixed[7:5], w_fixed[3]};

  // S1: codeword register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_code <= in_codeword;
    end
  end

  // S2: classified and corrected output register; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_single  <= 1'b0;
      r_out_double  <= 1'b0;
      r_out_err_pos <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data    <= w_data;
        r_out_single  <= w_single;
        r_out_double  <= w_double;
        r_out_err_pos <= w_err_pos;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_single  = r_out_single;
  assign out_double  = r_out_double;
  assign out_err_pos = r_out_err_pos;

`ifdef HAMMING_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_out_hs;
  logic [CNT_W-1:0] r_cnt_single;
  logic [CNT_W-1:0] r_cnt_double;

  assign w_out_hs = r_out_valid && out_ready;

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_single <= '0;
      r_cnt_double <= '0;
    end else if (stats_clear) begin
      r_cnt_single <= '0;
      r_cnt_double <= '0;
    end else if (w_out_hs) begin
      if (r_out_single && (r_cnt_single != CNT_MAX)) r_cnt_single <= r_cnt_single + CNT_W'(1);
      if (r_out_double && (r_cnt_double != CNT_MAX)) r_cnt_double <= r_cnt_double + CNT_W'(1);
    end
  end

  assign cnt_single = r_cnt_single;
  assign cnt_double = r_cnt_double;
`else
  logic w_unused_stats_clear;

  assign w_unused_stats_clear = stats_clear;
  assign cnt_single = '0;
  assign cnt_double = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder: the driver pushes hand-computed
// expectations on accept, and a negedge monitor pops and compares on every output handshake.
module tb_hamming_secded_decoder;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_codeword = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [10:0]      out_data;
  logic             out_single;
  logic             out_double;
  logic [3:0]       out_err_pos;
  logic             stats_clear = 1'b0;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;

  hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_single(out_single), .out_double(out_double), .out_err_pos(out_err_pos),
    .stats_clear(stats_clear), .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] data;
    logic        s;
    logic        d;
    logic [3:0]  pos;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   bp_mode = 0;
  bit   bp_checked = 0;
  int   bp_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Offer one word; expectation is queued at the negedge where in_ready says it will be taken.
  task automatic send(input logic [15:0] cw, input logic [10:0] d, input logic s,
                      input logic dd, input logic [3:0] p, input bit lat);
    bit done = 0;
    exp_t e;
    in_valid    = 1'b1;
    in_codeword = cw;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = d; e.s = s; e.d = dd; e.pos = p; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        done = 1;
        if (bp_mode) bp_acc++;
      end else if (bp_mode && !bp_checked) begin
        chk("bp_accepts_before_stall", 32'(bp_acc), 32'd2);
        bp_checked = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: hold stability, counter model, and scoreboard compare on handshakes.
  bit          armed = 0;
  logic [19:0] snap;
  int          m_s = 0;
  int          m_d = 0;

  always @(negedge clk) begin
    exp_t e;
    logic e_s, e_d;
    bit hs;
    if (rst) begin
      armed = 0; m_s = 0; m_d = 0;
    end else begin
      if (armed) chk("hold_stable", 32'({out_valid, out_data, out_single, out_double, out_err_pos}), 32'(snap));
      chk("cnt_single", 32'(cnt_single), 32'(m_s));
      chk("cnt_double", 32'(cnt_double), 32'(m_d));
      hs = out_valid && out_ready;
      e_s = 0; e_d = 0;
      if (hs) begin
        chk("sb_has_expect", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_fields", 32'({out_data, out_single, out_double, out_err_pos}),
              32'({e.data, e.s, e.d, e.pos}));
          if (e.lat) chk("latency", 32'(cyc), 32'(e.acc + 2));
          e_s = e.s; e_d = e.d;
        end
      end
`ifdef HAMMING_DEC_STATS_EN
      if (stats_clear) begin
        m_s = 0; m_d = 0;
      end else if (hs) begin
        if (e_s && m_s != CNT_MAX) m_s++;
        if (e_d && m_d != CNT_MAX) m_d++;
      end
`endif
      armed = out_valid && !out_ready;
      snap  = {out_valid, out_data, out_single, out_double, out_err_pos};
    end
  end

  initial begin
    bit got;
    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", 32'({out_data, out_single, out_double, out_err_pos}), 32'd0);
    chk("rst_counters", 32'({cnt_single, cnt_double}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Clean words back-to-back, then single/parity/double/boundary errors.
    send(16'h0000, 11'h000, 0, 0, 4'd0, 1);
    send(16'hFFFF, 11'h7FF, 0, 0, 4'd0, 1);
    send(16'hFFDF, 11'h7FF, 1, 0, 4'd5, 1);
    send(16'h0001, 11'h000, 1, 0, 4'd0, 1);
    send(16'h0220, 11'h012, 0, 1, 4'd0, 1);
    send(16'h0004, 11'h000, 1, 0, 4'd2, 1);
    send(16'h8000, 11'h000, 1, 0, 4'd15, 1);
    send(16'h000F, 11'h001, 0, 0, 4'd0, 1);
    send(16'h0007, 11'h001, 1, 0, 4'd3, 1);
    drain();

    // Back-pressure: 5-cycle stall while streaming 4 words.
    out_ready = 1'b0;
    bp_mode = 1; bp_acc = 0; bp_checked = 0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(16'h000F, 11'h001, 0, 0, 4'd0, 0);
        send(16'h0007, 11'h001, 1, 0, 4'd3, 0);
        send(16'h0220, 11'h012, 0, 1, 4'd0, 0);
        send(16'hFFFF, 11'h7FF, 0, 0, 4'd0, 0);
      end
    join
    bp_mode = 0;
    chk("bp_stall_seen", 32'(bp_checked), 32'd1);
    drain();

    // Saturation: five single errors, then a clear on the sixth handshake.
    send(16'h0001, 11'h000, 1, 0, 4'd0, 0);
    send(16'h0004, 11'h000, 1, 0, 4'd2, 0);
    send(16'h8000, 11'h000, 1, 0, 4'd15, 0);
    send(16'h0007, 11'h001, 1, 0, 4'd3, 0);
    send(16'hFFDF, 11'h7FF, 1, 0, 4'd5, 0);
    drain();
    out_ready = 1'b0;
    send(16'h0001, 11'h000, 1, 0, 4'd0, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    chk("sixth_word_present", 32'(got), 32'd1);
    @(posedge clk); #1;
    stats_clear = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    stats_clear = 1'b0;
    drain();

    // One counted single error, then a mid-stream reset.
    send(16'hFFDF, 11'h7FF, 1, 0, 4'd5, 0);
    drain();
    send(16'h0000, 11'h000, 0, 0, 4'd0, 0);
    send(16'hFFFF, 11'h7FF, 0, 0, 4'd0, 0);
    chk("pre_rst_in_flight", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_counters", 32'({cnt_single, cnt_double}), 32'd0);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(16'h0220, 11'h012, 0, 1, 4'd0, 1);
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
